// File: rtl/i2c_reg_pkg.sv
// rtl/i2c_reg_pkg.sv - shared host FSM encoding and default register-file geometry
package i2c_reg_pkg;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_ADDR_W   = 4;

  typedef enum logic [1:0] {
    HOST_IDLE   = 2'd0,
    HOST_ACCESS = 2'd1,
    HOST_ACK    = 2'd2
  } host_state_e;

endpackage

// File: rtl/i2c_reg_bank.sv
// rtl/i2c_reg_bank.sv - 8-bit register array, one write port, I2C and host read ports
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter int                      NUM_REGS  = DEF_NUM_REGS,
  parameter int                      ADDR_W    = DEF_ADDR_W,
  parameter logic [NUM_REGS*8-1:0]   RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] i2c_raddr,
  output logic [7:0]        i2c_rdata,
  input  logic [ADDR_W-1:0] host_raddr,
  output logic [7:0]        host_rdata
);

  logic [7:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= RESET_VAL[8*i +: 8];
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports see the pre-write contents during a write cycle.
  assign i2c_rdata  = mem[i2c_raddr];
  assign host_rdata = mem[host_raddr];

endmodule

// File: rtl/i2c_reg_arbiter.sv
// rtl/i2c_reg_arbiter.sv - I2C slave register file shared with a host port, I2C writes win
module i2c_reg_arbiter
  import i2c_reg_pkg::*;
#(
  parameter int                      NUM_REGS  = DEF_NUM_REGS,
  parameter int                      ADDR_W    = DEF_ADDR_W,
  parameter logic [NUM_REGS-1:0]     RO_MASK   = '0,
  parameter logic [NUM_REGS*8-1:0]   RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_read_req,
  output logic [7:0]        i2c_data_to_master,
  input  logic              i2c_data_valid,
  input  logic [7:0]        i2c_data_from_master,
  input  logic [7:0]        i2c_write_cycle_count,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  output logic              reg_wr_strobe,
  output logic [ADDR_W-1:0] reg_wr_addr
);

  host_state_e       state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              i2c_wr_evt;
  logic              i2c_commit;
  logic              host_done;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [7:0]        bank_wdata;
  logic [7:0]        bank_host_rdata;

  i2c_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (bank_we),
    .waddr      (bank_waddr),
    .wdata      (bank_wdata),
    .i2c_raddr  (ptr),
    .i2c_rdata  (i2c_data_to_master),
    .host_raddr (host_addr),
    .host_rdata (bank_host_rdata)
  );

  // A data byte after the first is a register write; read-only targets only advance ptr.
  always_comb begin
    i2c_wr_evt = i2c_data_valid && (i2c_write_cycle_count != 8'd0);
    i2c_commit = i2c_wr_evt && !RO_MASK[ptr];
  end

  // data_valid takes precedence over a colliding read_req, so ptr moves at most once.
  always_comb begin
    ptr_nxt = ptr;
    if (i2c_data_valid) begin
      if (i2c_write_cycle_count == 8'd0) begin
        ptr_nxt = i2c_data_from_master[ADDR_W-1:0];
      end else begin
        ptr_nxt = ptr + ADDR_W'(1);
      end
    end else if (i2c_read_req) begin
      ptr_nxt = ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    host_done = 1'b0;
    case (state)
      HOST_IDLE: begin
        if (host_req) state_nxt = HOST_ACCESS;
      end
      HOST_ACCESS: begin
        if (!i2c_commit) begin
          host_done = 1'b1;
          state_nxt = HOST_ACK;
        end
      end
      HOST_ACK: begin
        state_nxt = HOST_IDLE;
      end
      default: begin
        state_nxt = HOST_IDLE;
      end
    endcase
  end

  always_comb begin
    bank_we    = i2c_commit || (host_done && host_we);
    bank_waddr = host_addr;
    bank_wdata = host_wdata;
    if (i2c_commit) begin
      bank_waddr = ptr;
      bank_wdata = i2c_data_from_master;
    end
  end

  assign host_ack = (state == HOST_ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HOST_IDLE;
      ptr           <= '0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= '0;
      host_rdata    <= 8'h00;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      reg_wr_strobe <= i2c_commit;
      if (i2c_commit) reg_wr_addr <= ptr;
      if (host_done && !host_we) host_rdata <= bank_host_rdata;
    end
  end

endmodule

// File: doc/i2c_reg_arbiter.md
I2C_REG_ARBITER -- requirements
Module: i2c_reg_arbiter

Interface
REQ-001 Parameter NUM_REGS, default 16: number of 8-bit registers; a power of two, 2..256.
REQ-002 Parameter ADDR_W, default 4: pointer/address width, equal to log2(NUM_REGS).
REQ-003 Parameter RO_MASK, default all-zero, NUM_REGS bits: bit i set makes register i read-only to I2C; the host port can still write it.
REQ-004 Parameter RESET_VAL, default all-zero, NUM_REGS*8 bits: reset contents; register i occupies bits [8i+7:8i].
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 i2c_read_req  input  1  one-cycle read request pulse from the I2C slave.
REQ-008 i2c_data_to_master  output  8  byte the I2C slave samples on the read_req cycle.
REQ-009 i2c_data_valid  input  1  one-cycle pulse: a byte was received from the master.
REQ-010 i2c_data_from_master  input  8  received byte; valid when i2c_data_valid=1.
REQ-011 i2c_write_cycle_count  input  8  bytes already received this transaction (pre-increment value when data_valid=1).
REQ-012 host_req  input  1  host access request; held until host_ack.
REQ-013 host_we  input  1  1=write, 0=read; held with host_req.
REQ-014 host_addr  input  ADDR_W  host register address.
REQ-015 host_wdata  input  8  host write data.
REQ-016 host_rdata  output  8  host read data; valid when host_ack=1.
REQ-017 host_ack  output  1  one-cycle access-complete pulse.
REQ-018 reg_wr_strobe  output  1  one-cycle pulse on any committed I2C write.
REQ-019 reg_wr_addr  output  ADDR_W  address of the last committed I2C write.

Function
REQ-020 The block SHALL drive i2c_data_to_master = regs[ptr] combinationally at all times, so the byte is valid on the read_req cycle.
REQ-021 When i2c_data_valid=1 and i2c_write_cycle_count=0, the block SHALL load ptr with i2c_data_from_master[ADDR_W-1:0] and write no register.
REQ-022 When i2c_data_valid=1 and i2c_write_cycle_count!=0, the block SHALL write regs[ptr] (unless RO_MASK[ptr]=1), pulse reg_wr_strobe, set reg_wr_addr=ptr, and increment ptr, all on the next clock edge.
REQ-023 A write to a read-only register SHALL still increment ptr, with no reg_wr_strobe.
REQ-024 On i2c_read_req=1 the block SHALL increment ptr on the next edge.
REQ-025 ptr SHALL wrap from NUM_REGS-1 to 0.
REQ-026 Host FSM states: IDLE, ACCESS, ACK.
  - IDLE->ACCESS on host_req=1.
  - ACCESS->ACK when no I2C register write occurs that cycle; otherwise ACCESS is held (I2C has priority).
  - ACK: host_ack=1 for one cycle, then ->IDLE.
REQ-027 A host write SHALL commit in the ACCESS-exit cycle; a host read SHALL capture regs[host_addr] into host_rdata in that same cycle.
REQ-028 An I2C read and a host write to the same register in the same cycle: I2C SHALL receive the pre-write value.
REQ-029 Simultaneous i2c_read_req and i2c_data_valid SHALL be treated as a protocol error: perform the data_valid action only and increment ptr once.
REQ-030 host_rdata SHALL hold its value until the next host read completes.

Reset
REQ-031 While rst_n=0: regs=RESET_VAL, ptr=0, FSM=IDLE, host_ack=0, reg_wr_strobe=0, reg_wr_addr=0, host_rdata=0.
REQ-032 Reset mid-access SHALL abort the access without asserting host_ack; a pending host write SHALL be lost.

Structure
REQ-033 The host FSM state encoding and the default NUM_REGS/ADDR_W SHALL live in a shared package, i2c_reg_pkg.
REQ-034 The register array SHALL be a sub-module, i2c_reg_bank, with one write port, one combinational read port for I2C and one for the host.

Verification
REQ-035 I2C write 0x03,0xAA,0xBB -> regs[3]=0xAA, regs[4]=0xBB, ptr=5, two reg_wr_strobe pulses with reg_wr_addr 3 then 4.
REQ-036 Pointer 0x0F, then two read_req pulses -> data_to_master 0x(regs[15]) then regs[0]; ptr wraps 15->0.
REQ-037 RO_MASK[2]=1, I2C write 0x02,0x55 -> regs[2] unchanged, no strobe, ptr=3.
REQ-038 Host write addr 5 data 0x77 in the same cycle as I2C data_valid -> I2C write commits first, host_ack one cycle later, regs[5]=0x77.
REQ-039 Host read addr 1 after reset with RESET_VAL[15:8]=0x5A -> host_ack at cycle 2, host_rdata=0x5A.
REQ-040 rst_n low during ACCESS -> FSM=IDLE, no host_ack, regs restored to RESET_VAL.
